// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: s = a - b over WIDTH bits, CHUNK bits per clock, borrow rippled via a register.
// Optional signed-overflow output enabled by defining SEQ_SUB_OVF_EN.
module seq_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             EN,
  output logic             busy,
  output logic             done,
`ifdef SEQ_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   s
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_subtractor: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_n;
  logic               load_c, step_c, last_c;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               bor_q, res_msb_q, busy_q, done_q;
  logic [CHUNK-1:0]   res_q [NCHUNK];
  logic [CHUNK-1:0]   a_ch  [NCHUNK];
  logic [CHUNK-1:0]   b_ch  [NCHUNK];
  logic [CHUNK-1:0]   ach_c, bch_c, d_c;
  logic               bin_c, bout_c;
  logic [WIDTH-1:0]   diff_c;
`ifdef SEQ_SUB_OVF_EN
  logic               ovf_q;
`endif

  // Constant-index views of operands and result as chunk arrays
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    assign a_ch[g]                   = a_q[g*CHUNK +: CHUNK];
    assign b_ch[g]                   = b_q[g*CHUNK +: CHUNK];
    assign diff_c[g*CHUNK +: CHUNK]  = res_q[g];
  end

  assign last_c = (idx_q == IDX_W'(NCHUNK - 1));

  // Ripple of full subtractors across the current chunk
  always_comb begin
    ach_c = a_ch[idx_q];
    bch_c = b_ch[idx_q];
    bin_c = bor_q;
    d_c   = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      d_c[i] = ach_c[i] ^ bch_c[i] ^ bin_c;
      bin_c  = (~ach_c[i] & bch_c[i]) | (~ach_c[i] & bin_c) | (bch_c[i] & bin_c);
    end
    bout_c = bin_c;
  end

  always_comb begin
    state_n = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      bor_q     <= 1'b0;
      res_msb_q <= 1'b0;
      for (int i = 0; i < int'(NCHUNK); i++) res_q[i] <= '0;
`ifdef SEQ_SUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == RUN);
      done_q  <= (state_n == DONE);
      if (load_c) begin
        a_q   <= a;
        b_q   <= b;
        bor_q <= 1'b0;
        idx_q <= '0;
      end
      if (step_c) begin
        res_q[idx_q] <= d_c;
        bor_q        <= bout_c;
        idx_q        <= idx_q + 1'b1;
        if (last_c) begin
          res_msb_q <= bout_c;
`ifdef SEQ_SUB_OVF_EN
          ovf_q     <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_c[CHUNK-1]);
`endif
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = EN ? {res_msb_q, diff_c} : {(WIDTH+1){1'bz}};
`ifdef SEQ_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor: one W=8/C=1 and one W=8/C=4 instance against an arithmetic model.
module tb_seq_subtractor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [2];
  logic [7:0] a_in  [2];
  logic [7:0] b_in  [2];
  logic       en    [2];
  logic       busy_w[2];
  logic       done_w[2];
  wire  [8:0] s0, s1;
`ifdef SEQ_SUB_OVF_EN
  logic       ovf_w [2];
  bit         ovf_q0[$], ovf_q1[$];
`endif

  int         checks   = 0;
  int         failures = 0;
  int         overlap  = 0;
  logic [8:0] exp_q0[$], exp_q1[$];

  seq_subtractor #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_in[0]), .b(b_in[0]), .EN(en[0]),
    .busy(busy_w[0]), .done(done_w[0]),
`ifdef SEQ_SUB_OVF_EN
    .ovf(ovf_w[0]),
`endif
    .s(s0));

  seq_subtractor #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_in[1]), .b(b_in[1]), .EN(en[1]),
    .busy(busy_w[1]), .done(done_w[1]),
`ifdef SEQ_SUB_OVF_EN
    .ovf(ovf_w[1]),
`endif
    .s(s1));

  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    return {(x < y), 8'(x - y)};
  endfunction

  function automatic bit ref_ovf(input logic [7:0] x, input logic [7:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return (d > 127) || (d < -128);
  endfunction

  function automatic logic [8:0] s_of(input int u);
    return (u == 0) ? s0 : s1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // A released bus reads as Z on 4-state simulators and as 0 on 2-state ones
  task automatic check_z(input string name, input int u);
    logic [8:0] got;
    got = s_of(u);
    checks++;
    if (!((got === {9{1'bz}}) || (got === 9'h000))) begin
      failures++;
      $display("FAIL %s: got %0h expected released bus", name, got);
    end
  endtask

  task automatic push(input int u, input logic [7:0] x, input logic [7:0] y);
    if (u == 0) exp_q0.push_back(ref_sub(x, y));
    else        exp_q1.push_back(ref_sub(x, y));
`ifdef SEQ_SUB_OVF_EN
    if (u == 0) ovf_q0.push_back(ref_ovf(x, y));
    else        ovf_q1.push_back(ref_ovf(x, y));
`endif
  endtask

  // Monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    logic [8:0] want;
    bit         have;
`ifdef SEQ_SUB_OVF_EN
    bit         wovf;
`endif
    for (int u = 0; u < 2; u++) begin
      if (busy_w[u] && done_w[u]) overlap++;
      if (rst_n && done_w[u]) begin
        have = (u == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        if (!have) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected no pending op", u);
        end else begin
          if (u == 0) want = exp_q0.pop_front();
          else        want = exp_q1.pop_front();
          if (en[u]) check($sformatf("s_dut%0d", u), 32'(s_of(u)), 32'(want));
          else       check_z($sformatf("s_z_dut%0d", u), u);
`ifdef SEQ_SUB_OVF_EN
          if (u == 0) wovf = ovf_q0.pop_front();
          else        wovf = ovf_q1.pop_front();
          check($sformatf("ovf_dut%0d", u), 32'(ovf_w[u]), 32'(wovf));
`endif
        end
      end
    end
  end

  task automatic start_pulse(input int u, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a_in[u]  = x;
    b_in[u]  = y;
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    a_in[u]  = 8'($urandom);
    b_in[u]  = 8'($urandom);
  endtask

  // One op: checks busy length and start-to-done latency; optional re-start during RUN
  task automatic run_op(input int u, input logic [7:0] x, input logic [7:0] y,
                        input int nch, input bit repulse);
    int cyc, bcnt;
    push(u, x, y);
    start_pulse(u, x, y);
    check("busy_after_start", 32'(busy_w[u]), 32'd1);
    cyc  = 1;
    bcnt = 0;
    while (!done_w[u] && cyc <= nch + 8) begin
      if (busy_w[u]) bcnt++;
      if (repulse && cyc == 2) begin
        a_in[u] = 8'h00; b_in[u] = 8'h01; start[u] = 1'b1;
      end else begin
        start[u] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start[u] = 1'b0;
    if (!done_w[u]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout dut%0d: got no done after %0d cycles expected %0d", u, cyc, nch + 1);
    end else begin
      check("latency", 32'(cyc), 32'(nch + 1));
      check("busy_cycles", 32'(bcnt), 32'(nch));
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  cnt, cyc, t1, t3;
    bit  seen;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; en[u] = 1'b1; a_in[u] = 8'h00; b_in[u] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", 32'(busy_w[0]), 32'd0);
    check("rst_done0", 32'(done_w[0]), 32'd0);
    check("rst_busy1", 32'(busy_w[1]), 32'd0);
    check("rst_s0",    32'(s0), 32'd0);
    check("rst_s1",    32'(s1), 32'd0);
    rst_n = 1'b1;

    run_op(0, 8'd10, 8'd3, 8, 1'b0);
    run_op(0, 8'd3, 8'd10, 8, 1'b0);
    run_op(1, 8'h00, 8'h01, 2, 1'b0);
    run_op(1, 8'hA5, 8'hA5, 2, 1'b0);
    run_op(0, 8'd10, 8'd3, 8, 1'b1);
    run_op(0, 8'h80, 8'h01, 8, 1'b0);
    run_op(0, 8'h05, 8'h03, 8, 1'b0);
    run_op(1, 8'h7F, 8'hFF, 2, 1'b0);

    // Output released while disabled, then the held result reappears
    en[0] = 1'b0;
    run_op(0, 8'h55, 8'h20, 8, 1'b0);
    repeat (2) @(negedge clk);
    check_z("s_z_idle", 0);
    en[0] = 1'b1;
    #1;
    check("s_after_en", 32'(s0), 32'h035);
    check("busy_after_en", 32'(busy_w[0]), 32'd0);

    // Start held high: back-to-back ops, one every CHUNKS+2 cycles
    @(negedge clk);
    a_in[1] = 8'd9; b_in[1] = 8'd4; start[1] = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 8'd9, 8'd4);
    cnt = 0; cyc = 0; t1 = 0; t3 = 0;
    while (cnt < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done_w[1]) begin
        cnt++;
        if (cnt == 1) t1 = cyc;
        if (cnt == 3) t3 = cyc;
      end
    end
    start[1] = 1'b0;
    check("b2b_count", 32'(cnt), 32'd3);
    check("b2b_spacing", 32'(t3 - t1), 32'd8);
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN aborts with no done pulse
    start_pulse(0, 8'd10, 8'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_done", 32'(done_w[0]), 32'd0);
    check("midrst_s",    32'(s0), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done_w[0];
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    for (int i = 0; i < 24; i++) begin
      run_op(i % 2, 8'($urandom), 8'($urandom), ((i % 2) == 1) ? 2 : 8, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue0_empty", 32'(exp_q0.size()), 32'd0);
    check("queue1_empty", 32'(exp_q1.size()), 32'd0);
    check("busy_done_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
